// File: rtl/fwd_scoreboard_unit_if.sv
// EX-stage forwarding/hazard bus: instruction-in-EX fields, long-latency writeback
// notification, and the resulting forwarding selects, stall and outstanding count.
interface fwd_scoreboard_unit_if #(
   parameter int NUM_SRC    = 3,
   parameter int FWD_STAGES = 2,
   parameter int MAX_LL     = 4
);
   localparam int SEL_W = $clog2(FWD_STAGES + 2);
   localparam int CNT_W = $clog2(MAX_LL + 1);

   logic                     ex_valid;
   logic [NUM_SRC*5-1:0]     ex_src_addr;
   logic [NUM_SRC-1:0]       ex_src_file;
   logic [NUM_SRC-1:0]       ex_src_en;
   logic [4:0]               ex_dst_addr;
   logic                     ex_dst_file;
   logic                     ex_write_en;
   logic                     ex_is_load;
   logic                     ex_long_lat;
   logic                     advance;
   logic                     flush;
   logic                     ll_done;
   logic [4:0]               ll_done_addr;
   logic                     ll_done_file;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic                     stall;
   logic [CNT_W-1:0]         ll_count;

   modport master (
      output ex_valid, ex_src_addr, ex_src_file, ex_src_en, ex_dst_addr, ex_dst_file,
             ex_write_en, ex_is_load, ex_long_lat, advance, flush,
             ll_done, ll_done_addr, ll_done_file,
      input  fwd_sel, stall, ll_count
   );

   modport slave (
      input  ex_valid, ex_src_addr, ex_src_file, ex_src_en, ex_dst_addr, ex_dst_file,
             ex_write_en, ex_is_load, ex_long_lat, advance, flush,
             ll_done, ll_done_addr, ll_done_file,
      output fwd_sel, stall, ll_count
   );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// EX operand forwarding + hazard unit with its own post-EX writer pipeline and LL scoreboard.
// Selects/stall are combinational from state and EX inputs; state updates on the next clk edge.
module fwd_scoreboard_unit #(
   parameter int NUM_SRC          = 3,
   parameter int FWD_STAGES       = 2,
   parameter int LOAD_READY_STAGE = 2,
   parameter int MAX_LL           = 4
) (
   input logic                 clk_i,
   input logic                 rst_i,
   fwd_scoreboard_unit_if.slave bus
);
   localparam int SEL_W = $clog2(FWD_STAGES + 2);
   localparam int CNT_W = $clog2(MAX_LL + 1);
   localparam logic [SEL_W-1:0] SEL_LL = SEL_W'(FWD_STAGES + 1);

   logic [FWD_STAGES-1:0] stg_vld_q, stg_vld_d;
   logic [FWD_STAGES-1:0] stg_file_q, stg_file_d;
   logic [FWD_STAGES-1:0] stg_load_q, stg_load_d;
   logic [4:0]            stg_addr_q [FWD_STAGES];
   logic [4:0]            stg_addr_d [FWD_STAGES];
   logic [63:0]           pend_q, pend_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                     eff_wr;
   logic [5:0]               dst_idx;
   logic [5:0]               done_idx;
   logic [NUM_SRC*SEL_W-1:0] fwd_sel;
   logic [NUM_SRC-1:0]       src_stall;
   logic                     waw, ll_full, stall, issue, ll_set, ll_clr;

   // Integer x0 is hardwired; writing it is not a real write.
   assign eff_wr   = bus.ex_write_en && !(!bus.ex_dst_file && bus.ex_dst_addr == 5'd0);
   assign dst_idx  = {bus.ex_dst_file, bus.ex_dst_addr};
   assign done_idx = {bus.ll_done_file, bus.ll_done_addr};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      logic [4:0]       a;
      logic             f;
      logic             chk;
      logic             bus_hit;
      logic             hit;
      logic             hit_ld;
      logic [SEL_W-1:0] s;

      assign a       = bus.ex_src_addr[5*g +: 5];
      assign f       = bus.ex_src_file[g];
      assign chk     = bus.ex_valid && bus.ex_src_en[g] && !(!f && a == 5'd0);
      assign bus_hit = bus.ll_done && bus.ll_done_addr == a && bus.ll_done_file == f;

      // Scan oldest to youngest so the youngest matching writer is the one that sticks.
      always_comb begin
         hit    = 1'b0;
         hit_ld = 1'b0;
         s      = '0;
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_vld_q[k] && stg_addr_q[k] == a && stg_file_q[k] == f) begin
               hit    = 1'b1;
               s      = SEL_W'(k + 1);
               hit_ld = stg_load_q[k] && ((k + 1) < LOAD_READY_STAGE);
            end
         end
         if (!hit && bus_hit) begin
            s = SEL_LL;
         end
      end

      assign fwd_sel[SEL_W*g +: SEL_W] = chk ? s : '0;
      assign src_stall[g] = chk && (hit_ld || (pend_q[{f, a}] && !bus_hit));
   end

   assign waw     = eff_wr && pend_q[dst_idx];
   assign ll_full = bus.ex_long_lat && eff_wr && (cnt_q == CNT_W'(MAX_LL));
   assign stall   = bus.ex_valid && ((|src_stall) || waw || ll_full);
   assign issue   = bus.ex_valid && !stall && !bus.flush;
   assign ll_set  = issue && bus.advance && bus.ex_long_lat && eff_wr;
   assign ll_clr  = bus.ll_done && pend_q[done_idx];

   always_comb begin
      stg_vld_d  = stg_vld_q;
      stg_file_d = stg_file_q;
      stg_load_d = stg_load_q;
      stg_addr_d = stg_addr_q;
      if (bus.advance) begin
         for (int k = FWD_STAGES - 1; k > 0; k--) begin
            stg_vld_d[k]  = stg_vld_q[k-1];
            stg_file_d[k] = stg_file_q[k-1];
            stg_load_d[k] = stg_load_q[k-1];
            stg_addr_d[k] = stg_addr_q[k-1];
         end
         // Long-latency results come back out-of-band, so they never occupy a stage.
         stg_vld_d[0]  = issue && eff_wr && !bus.ex_long_lat;
         stg_file_d[0] = bus.ex_dst_file;
         stg_load_d[0] = bus.ex_is_load;
         stg_addr_d[0] = bus.ex_dst_addr;
      end
      pend_d = pend_q;
      if (ll_clr) begin
         pend_d[done_idx] = 1'b0;
      end
      if (ll_set) begin
         pend_d[dst_idx] = 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(ll_set) - CNT_W'(ll_clr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stg_vld_q  <= '0;
         stg_file_q <= '0;
         stg_load_q <= '0;
         stg_addr_q <= '{default: '0};
         pend_q     <= '0;
         cnt_q      <= '0;
      end else begin
         stg_vld_q  <= stg_vld_d;
         stg_file_q <= stg_file_d;
         stg_load_q <= stg_load_d;
         stg_addr_q <= stg_addr_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.fwd_sel  = fwd_sel;
   assign bus.stall    = stall;
   assign bus.ll_count = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed vector table, reset corner case, then random
// stimulus checked against a queue/set based reference model.
module tb_fwd_scoreboard_unit;
   localparam int NUM_SRC    = 3;
   localparam int FWD_STAGES = 2;
   localparam int LRS        = 2;
   localparam int MAX_LL     = 4;
   localparam int NVEC       = 25;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fwd_scoreboard_unit_if #(.NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .MAX_LL(MAX_LL)) bus ();

   fwd_scoreboard_unit #(
      .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .LOAD_READY_STAGE(LRS), .MAX_LL(MAX_LL)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   typedef struct {
      logic        vld;
      logic [14:0] sa;
      logic [2:0]  sf;
      logic [2:0]  se;
      logic [4:0]  da;
      logic        df;
      logic        wr;
      logic        ld;
      logic        ll;
      logic        adv;
      logic        fl;
      logic        lld;
      logic [4:0]  la;
      logic        lf;
   } in_t;

   typedef struct {
      in_t        i;
      logic [5:0] sel;
      logic       st;
      logic [2:0] cnt;
   } vec_t;

   typedef struct {
      bit       v;
      bit [4:0] a;
      bit       f;
      bit       ld;
   } ent_t;

   ent_t mstg[$];
   bit   mpend[int];
   int   errs = 0;
   int   checks = 0;
   vec_t tab[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int key(input bit f, input bit [4:0] a);
      return int'(f) * 32 + int'(a);
   endfunction

   function automatic in_t idle();
      in_t x;
      x = '{default: '0};
      return x;
   endfunction

   // rd/rs are {file, addr}; only source 0 is populated.
   function automatic in_t op(input logic [5:0] rd, input logic wr, input logic ld,
                              input logic ll, input logic [5:0] rs, input logic en,
                              input logic adv, input logic fl);
      in_t x;
      x     = idle();
      x.vld = 1'b1;
      x.sa  = {10'd0, rs[4:0]};
      x.sf  = {2'b00, rs[5]};
      x.se  = {2'b00, en};
      x.da  = rd[4:0];
      x.df  = rd[5];
      x.wr  = wr;
      x.ld  = ld;
      x.ll  = ll;
      x.adv = adv;
      x.fl  = fl;
      return x;
   endfunction

   task automatic drive(input in_t x);
      bus.ex_valid     = x.vld;
      bus.ex_src_addr  = x.sa;
      bus.ex_src_file  = x.sf;
      bus.ex_src_en    = x.se;
      bus.ex_dst_addr  = x.da;
      bus.ex_dst_file  = x.df;
      bus.ex_write_en  = x.wr;
      bus.ex_is_load   = x.ld;
      bus.ex_long_lat  = x.ll;
      bus.advance      = x.adv;
      bus.flush        = x.fl;
      bus.ll_done      = x.lld;
      bus.ll_done_addr = x.la;
      bus.ll_done_file = x.lf;
   endtask

   function automatic bit eff_write(input in_t x);
      return x.wr && !(!x.df && x.da == 5'd0);
   endfunction

   function automatic void model_eval(input in_t x, output logic [5:0] sel, output logic st);
      sel = '0;
      st  = 1'b0;
      if (!x.vld) return;
      for (int i = 0; i < NUM_SRC; i++) begin
         bit [4:0] a;
         bit       f;
         bit       busm;
         int       hit;
         a    = x.sa[5*i +: 5];
         f    = x.sf[i];
         hit  = 0;
         busm = x.lld && x.la == a && x.lf == f;
         if (!x.se[i] || (!f && a == 5'd0)) continue;
         for (int k = 0; k < mstg.size(); k++) begin
            if (hit == 0 && mstg[k].v && mstg[k].a == a && mstg[k].f == f) begin
               hit = k + 1;
               if (mstg[k].ld && hit < LRS) st = 1'b1;
            end
         end
         if (hit != 0) sel[2*i +: 2] = 2'(hit);
         else if (busm) sel[2*i +: 2] = 2'(FWD_STAGES + 1);
         if (mpend.exists(key(f, a)) && !busm) st = 1'b1;
      end
      if (eff_write(x) && mpend.exists(key(x.df, x.da))) st = 1'b1;
      if (x.ll && eff_write(x) && mpend.num() == MAX_LL) st = 1'b1;
   endfunction

   function automatic void model_update(input in_t x, input logic st);
      bit   issue;
      ent_t e;
      issue = x.vld && !st && !x.fl;
      if (x.adv) begin
         e.v  = issue && eff_write(x) && !x.ll;
         e.a  = x.da;
         e.f  = x.df;
         e.ld = x.ld;
         mstg.push_front(e);
         void'(mstg.pop_back());
      end
      if (x.lld && mpend.exists(key(x.lf, x.la))) mpend.delete(key(x.lf, x.la));
      if (issue && x.adv && x.ll && eff_write(x)) mpend[key(x.df, x.da)] = 1'b1;
   endfunction

   function automatic void model_reset();
      ent_t e;
      e = '{default: '0};
      mstg.delete();
      for (int k = 0; k < FWD_STAGES; k++) mstg.push_back(e);
      mpend.delete();
   endfunction

   // One cycle: drive after the edge, compare at negedge, advance the model at posedge.
   task automatic step(input in_t x, input bit use_tab, input logic [5:0] esel,
                       input logic est, input logic [2:0] ecnt, input string tag);
      logic [5:0] msel;
      logic       mst;
      drive(x);
      @(negedge clk);
      model_eval(x, msel, mst);
      if (use_tab) begin
         chk({tag, " sel"},   32'(bus.fwd_sel),  32'(esel));
         chk({tag, " stall"}, 32'(bus.stall),    32'(est));
         chk({tag, " count"}, 32'(bus.ll_count), 32'(ecnt));
      end else begin
         chk({tag, " sel"},   32'(bus.fwd_sel),  32'(msel));
         chk({tag, " stall"}, 32'(bus.stall),    32'(mst));
         chk({tag, " count"}, 32'(bus.ll_count), 32'(mpend.num()));
      end
      @(posedge clk);
      model_update(x, mst);
      #1;
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      drive(idle());
      repeat (n) @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      in_t x;

      tab[0]  = '{idle(), 6'd0, 1'b0, 3'd0};
      tab[1]  = '{op(6'd5, 1, 0, 0, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd0};
      tab[2]  = '{op(6'd0, 0, 0, 0, 6'd5, 1, 1, 0), 6'd1, 1'b0, 3'd0};
      tab[3]  = '{op(6'd0, 0, 0, 0, 6'd5, 1, 1, 0), 6'd2, 1'b0, 3'd0};
      tab[4]  = '{op(6'd0, 0, 0, 0, 6'd5, 1, 0, 0), 6'd0, 1'b0, 3'd0};
      tab[5]  = '{op(6'd7, 1, 1, 0, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd0};
      tab[6]  = '{op(6'd0, 0, 0, 0, 6'd7, 1, 1, 0), 6'd1, 1'b1, 3'd0};
      tab[7]  = '{op(6'd0, 0, 0, 0, 6'd7, 1, 1, 0), 6'd2, 1'b0, 3'd0};
      tab[8]  = '{op(6'h23, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd0};
      tab[9]  = '{op(6'h24, 1, 0, 0, 6'h23, 1, 1, 0), 6'd0, 1'b1, 3'd1};
      x = op(6'h24, 1, 0, 0, 6'h23, 1, 1, 0);
      x.lld = 1'b1; x.la = 5'd3; x.lf = 1'b1;
      tab[10] = '{x, 6'd3, 1'b0, 3'd1};
      tab[11] = '{idle(), 6'd0, 1'b0, 3'd0};
      tab[12] = '{op(6'd0, 1, 0, 0, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd0};
      tab[13] = '{op(6'h20, 1, 0, 0, 6'd0, 1, 1, 0), 6'd0, 1'b0, 3'd0};
      x = op(6'd0, 0, 0, 0, 6'h20, 1, 0, 0);
      x.se[1] = 1'b1;
      tab[14] = '{x, 6'b000001, 1'b0, 3'd0};
      tab[15] = '{op(6'h21, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd0};
      tab[16] = '{op(6'h22, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd1};
      tab[17] = '{op(6'h23, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd2};
      tab[18] = '{op(6'h24, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd3};
      x = op(6'h25, 1, 0, 1, 6'd0, 0, 1, 0);
      x.lld = 1'b1; x.la = 5'd1; x.lf = 1'b1;
      tab[19] = '{x, 6'd0, 1'b1, 3'd4};
      tab[20] = '{op(6'h25, 1, 0, 1, 6'd0, 0, 1, 0), 6'd0, 1'b0, 3'd3};
      tab[21] = '{idle(), 6'd0, 1'b0, 3'd4};
      tab[22] = '{op(6'd9, 1, 0, 0, 6'd0, 0, 1, 1), 6'd0, 1'b0, 3'd4};
      tab[23] = '{op(6'd0, 0, 0, 0, 6'd9, 1, 0, 0), 6'd0, 1'b0, 3'd4};
      tab[24] = '{op(6'h22, 1, 0, 0, 6'd0, 0, 0, 0), 6'd0, 1'b1, 3'd4};

      reset_cycles(2);
      rst = 1'b1;
      #1;
      @(negedge clk);
      chk("reset count", 32'(bus.ll_count), 32'd0);
      chk("reset stall", 32'(bus.stall),    32'd0);
      chk("reset sel",   32'(bus.fwd_sel),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int n = 0; n < NVEC; n++) begin
         step(tab[n].i, 1'b1, tab[n].sel, tab[n].st, tab[n].cnt, $sformatf("vec%0d", n));
      end

      // Reset with f2..f5 pending and an x6 writer in flight: everything must be forgotten.
      step(op(6'd6, 1, 0, 0, 6'd0, 0, 1, 0), 1'b1, 6'd0, 1'b0, 3'd4, "pre_reset");
      reset_cycles(1);
      x = op(6'd0, 0, 0, 0, 6'd6, 1, 0, 0);
      x.lld = 1'b1; x.la = 5'd2; x.lf = 1'b1;
      step(x, 1'b1, 6'd0, 1'b0, 3'd0, "post_reset x6 / late done");
      step(op(6'd0, 0, 0, 0, 6'h23, 1, 1, 0), 1'b1, 6'd0, 1'b0, 3'd0, "post_reset f3 read");

      for (int n = 0; n < 3000; n++) begin
         x     = idle();
         x.vld = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NUM_SRC; i++) begin
            x.sa[5*i +: 5] = 5'($urandom_range(0, 3));
            x.sf[i]        = 1'($urandom_range(0, 1));
            x.se[i]        = 1'($urandom_range(0, 1));
         end
         x.da  = 5'($urandom_range(0, 3));
         x.df  = 1'($urandom_range(0, 1));
         x.wr  = ($urandom_range(0, 3) != 0);
         x.ld  = x.wr && ($urandom_range(0, 3) == 0);
         x.ll  = ($urandom_range(0, 3) == 0);
         x.adv = ($urandom_range(0, 3) != 0);
         x.fl  = ($urandom_range(0, 7) == 0);
         x.lld = ($urandom_range(0, 2) == 0);
         x.la  = 5'($urandom_range(0, 3));
         x.lf  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) begin
            reset_cycles(1);
         end
         step(x, 1'b0, 6'd0, 1'b0, 3'd0, $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Next-generation EX-stage operand forwarding and hazard unit for the RV32IMF pipeline.
- Owns its own record of in-flight writers across a parametrised number of post-EX stages, so it no longer takes MEM/WB addresses as inputs.
- Keeps a per-register pending scoreboard for long-latency units (FPU div/sqrt, M-extension divider) that write back out-of-band.
- Produces per-source forwarding selects and a single STALL for the pipeline controller.

Parameters:
- NUM_SRC, 3, number of source operands checked.
- FWD_STAGES, 2, post-EX stages tracked (stage 1 = MEM … stage FWD_STAGES = last forwardable stage).
- LOAD_READY_STAGE, 2, first stage index at which a load result is forwardable (range 1..FWD_STAGES).
- MAX_LL, 4, maximum outstanding long-latency writes.
- SEL_W, $clog2(FWD_STAGES+2), width of each forwarding select.
- CNT_W, $clog2(MAX_LL+1), width of the outstanding counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- EX_VALID  in  1  valid instruction in EX.
- EX_SRC_ADDR  in  NUM_SRC*5  source addresses; source i at [5i+4:5i].
- EX_SRC_FILE  in  NUM_SRC  0=int, 1=float, per source.
- EX_SRC_EN  in  NUM_SRC  source i is actually read.
- EX_DST_ADDR  in  5  destination address.
- EX_DST_FILE  in  1  0=int, 1=float.
- EX_WRITE_EN  in  1  instruction writes a register.
- EX_IS_LOAD  in  1  instruction is a load.
- EX_LONG_LAT  in  1  instruction issues to a long-latency unit.
- ADVANCE  in  1  post-EX stages shift this cycle.
- FLUSH  in  1  kill the EX instruction.
- LL_DONE  in  1  long-latency result on the writeback bus this cycle.
- LL_DONE_ADDR  in  5  register address of that result.
- LL_DONE_FILE  in  1  register file of that result.
- FWD_SEL  out  NUM_SRC*SEL_W  select for source i at [SEL_W*i +: SEL_W]; 0 = register file, k = stage k (1..FWD_STAGES), FWD_STAGES+1 = LL bus.
- STALL  out  1  hold the EX instruction.
- LL_COUNT  out  CNT_W  outstanding long-latency writes.

Behaviour:
- Single clock CLK; synchronous active-high RESET.
- State:
  - Stage array of FWD_STAGES entries {valid, addr, file, is_load}.
  - pending[64], indexed {file, addr}.
  - LL_COUNT.
- RESET: all entries invalid, pending all 0, LL_COUNT 0.
  - Registered outputs are 0.
  - FWD_SEL and STALL are 0 while EX_VALID=0.
  - RESET mid-operation discards all tracked writers; a later LL_DONE for them is ignored.
- Effective write: EX_WRITE_EN and not (EX_DST_FILE=0 and EX_DST_ADDR=0). Integer x0 is never tracked, forwarded or stalled on. Float f0 is an ordinary register.
- A source is checked only if EX_VALID, EX_SRC_EN[i] is set, and it is not integer x0.
- A stage entry matches a source when valid, addr equal and file equal.
- FWD_SEL[i], combinational, youngest writer wins:
  - Lowest-index matching stage k gives k.
  - Otherwise, LL_DONE with matching addr/file gives FWD_STAGES+1.
  - Otherwise 0.
- STALL (combinational, EX_VALID gated, independent of ADVANCE) is the OR of:
  - Load-use: the youngest matching stage k holds a load and k < LOAD_READY_STAGE.
  - RAW on LL: pending[src] is set and the LL bus does not match that source this cycle.
  - WAW on LL: effective write and pending[dst] set, regardless of LL_DONE.
  - LL full: EX_LONG_LAT, effective write, and LL_COUNT==MAX_LL, regardless of LL_DONE.
- Issue: EX_VALID and !STALL and !FLUSH.
- Shift, on ADVANCE:
  - Entry k+1 takes entry k.
  - Entry 1 takes the EX instruction if it issues with an effective write and !EX_LONG_LAT; otherwise entry 1 becomes invalid (bubble).
  - ADVANCE=0: array holds.
- LL issue: issue with ADVANCE, EX_LONG_LAT and an effective write sets pending[dst] and increments LL_COUNT. LL ops never enter the stage array.
- LL_DONE: clears pending[{file,addr}] and decrements LL_COUNT if that bit was set. LL_DONE for a non-pending register is ignored with no count change.
- Same-cycle LL issue and LL_DONE:
  - Different registers: count unchanged, one bit set, one bit cleared.
  - Same register: cannot occur, because the WAW check stalls it.
- FLUSH only suppresses insertion; older stages and the scoreboard are unaffected.

Test Plan:
- Int add x5 issued, ADVANCE=1 one cycle; next EX reads x5 as src0 → FWD_SEL[src0]=1, STALL=0. After a second ADVANCE → FWD_SEL=2. After a third → 0.
- Load to x7, then a dependent instruction in EX on the next cycle (LOAD_READY_STAGE=2) → STALL=1, stage 1 receives a bubble. After the next ADVANCE → STALL=0, FWD_SEL=2.
- FDIV f3 issued (LL_COUNT→1); fadd reading f3 → STALL=1 until LL_DONE with addr 3, file 1. That cycle → STALL=0, FWD_SEL=3. LL_COUNT→0 next cycle.
- Source x0 with a stage-1 entry for x0 attempted (int, WRITE_EN=1) → no entry created, FWD_SEL=0. A float source f0 with a stage-1 f0 writer → FWD_SEL=1.
- Four LL issues to f1..f4 → LL_COUNT=4. A fifth LL op → STALL=1 even with a simultaneous LL_DONE f1. Next cycle LL_COUNT=3 → STALL=0.
- FLUSH during a valid int write with ADVANCE → stage 1 invalid. RESET with two pending LL ops → LL_COUNT=0, pending cleared; a later LL_DONE is ignored.
